sysid_verifier: RTL

Sequencer that reads the two words of the system-ID slave and checks them against build-time expected values. After reset it automatically reads the ID word (address 0) and then the timestamp word (address 1) over a single-bit-address Avalon-MM read master. It latches both words and raises pass/fail flags. Software or a boot FSM can re-trigger a check with start, and an unresponsive slave is caught by a per-access timeout.

---
 rtl/sysid_verifier.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sysid_verifier.sv
// ---------------------------------------------------------------------------
// sysid_verifier
//
// Reads the two words of the system-ID slave (address 0 = ID, address 1 =
// build timestamp) over a single-bit-address Avalon-MM read master. It
// compares them against the values expected at build time. It runs one
// check automatically after reset (AUTO_START) and one more each time start
// is pulsed. A per-access timeout catches a slave that never drops
// waitrequest.
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   start             single-cycle request for a new check
//   avm_address       word select (0 = ID, 1 = timestamp), registered
//   avm_read          read strobe, registered
//   avm_readdata      slave read data (zero read latency)
//   avm_waitrequest   slave stall
//   busy              check in progress (RD_ID, RD_TS, FINISH)
//   done              one-cycle pulse when a check completes
//   id_ok, ts_ok      last captured words match the expected values
//   timeout_err       last check was aborted by the access timeout
//   id_value          last captured ID word
//   ts_value          last captured timestamp word
// ---------------------------------------------------------------------------
module sysid_verifier #(
    parameter logic [31:0] EXPECTED_ID    = 32'd890010046,
    parameter logic [31:0] EXPECTED_TS    = 32'd1219088571,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ID  = 2'd1,
        RD_TS  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // The counter value seen in the last stalled cycle before the abort.
    localparam logic [15:0] LAST_STALL = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic        pending;
    logic [15:0] wait_cnt;
    logic        in_read;
    logic        accept;
    logic        stalled;
    logic        expire;

    // ---------------------------------------------------------------------
    // Next-state and decoded outputs
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case statement leaves one unassigned and infers a latch.
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;

        in_read = (state == RD_ID) || (state == RD_TS);
        accept  = in_read && avm_read && !avm_waitrequest;
        stalled = in_read && avm_waitrequest;
        // Aborts at the end of the TIMEOUT_CYCLES-th consecutive stall cycle.
        expire  = stalled && (wait_cnt == LAST_STALL);

        unique case (state)
            IDLE: begin
                if (start || pending) next_state = RD_ID;
            end
            RD_ID: begin
                busy = 1'b1;
                if (expire)      next_state = FINISH;
                else if (accept) next_state = RD_TS;
            end
            RD_TS: begin
                busy = 1'b1;
                if (expire || accept) next_state = FINISH;
            end
            FINISH: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state is assigned with <= so every flop samples the values
        // that were present before the edge, whatever the order of blocks.
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // ---------------------------------------------------------------------
    // Bus strobes, timeout counter, start latch and result registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending     <= AUTO_START;
            wait_cnt    <= '0;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            // Leaving IDLE consumes the request. Starts that arrive at any
            // other time collapse into one extra check.
            if (state == IDLE && next_state == RD_ID) pending <= 1'b0;
            else if (start)                           pending <= 1'b1;

            // A non-stalled cycle (including the accept cycle that enters
            // RD_TS) clears the count, so each access starts from zero.
            if (stalled) wait_cnt <= wait_cnt + 16'd1;
            else         wait_cnt <= '0;

            // Derived from next_state so the strobes are registered. They
            // stay constant for as long as the slave stalls.
            avm_read    <= (next_state == RD_ID) || (next_state == RD_TS);
            avm_address <= (next_state == RD_TS);

            if (state == RD_ID && accept) id_value <= avm_readdata;
            if (state == RD_TS && accept) ts_value <= avm_readdata;

            // Flags are updated on the edge that enters FINISH, so they are
            // already valid in the cycle where done is high. The timestamp
            // comparison uses the word being captured on this same edge.
            if (expire) begin
                timeout_err <= 1'b1;
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
            end else if (state == RD_TS && accept) begin
                timeout_err <= 1'b0;
                id_ok       <= (id_value == EXPECTED_ID);
                ts_ok       <= (avm_readdata == EXPECTED_TS);
            end
        end
    end

endmodule
